load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte-address width of req_addr and mem_addr.
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  req_valid  in  1  pipeline access request.
  req_ready  out  1  unit idle, request accepted when req_valid & req_ready.
  req_we  in  1  1 = store, 0 = load.
  req_funct3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
  req_addr  in  ADDR_W  byte address.
  req_wdata  in  32  store data, little-endian.
  resp_valid  out  1  one-cycle completion pulse.
  resp_rdata  out  32  extended load data, 0 for stores and errors.
  resp_err  out  1  illegal or misaligned access, valid with resp_valid.
  mem_req  out  1  bus request, held until granted.
  mem_we  out  1  bus write.
  mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 00.
  mem_wdata  out  32  lane-positioned write data.
  mem_wstrb  out  4  byte-lane enables, 0000 on reads.
  mem_gnt  in  1  bus accepts the current request.
  mem_rvalid  in  1  completion for the oldest granted request, reads and writes.
  mem_rdata  in  32  read word, valid with mem_rvalid.

Function
REQ-003 SHALL use the FSM states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP. req_ready SHALL be 1 only in IDLE.
REQ-004 SHALL latch all req_* fields on acceptance. The next state SHALL be REQ0, or RESP for an error.
REQ-005 SHALL assert mem_req in REQ0 and REQ1 only. All mem_* outputs SHALL stay stable until mem_gnt, then go to WAIT0 or WAIT1.
REQ-006 SHALL allow at most one outstanding bus request. mem_rvalid SHALL be ignored outside WAIT0 and WAIT1.
REQ-007 SHALL define size = 1, 2 or 4 bytes and off = addr[1:0]. Byte k of the access SHALL map to lane (off+k) of word addr[ADDR_W-1:2].
REQ-008 For stores, mem_wdata SHALL be req_wdata shifted left by 8*off, and mem_wstrb SHALL set the lanes off..off+size-1 that fall in the current word.
REQ-009 For loads, the unit SHALL extract the bytes from mem_rdata. funct3 000 and 001 SHALL sign-extend. 100 and 101 SHALL zero-extend.
REQ-010 A non-spanning access SHALL use one transaction: WAIT0 on mem_rvalid goes to RESP.
REQ-011 RESP SHALL last one cycle with resp_valid=1, then go to IDLE. Best case is 3 cycles from acceptance to resp_valid, with mem_gnt and mem_rvalid each arriving the first cycle possible.
REQ-012 The unit SHALL flag an illegal access (resp_err=1, no bus activity) when a load has funct3 011, 110 or 111, or a store has funct3 other than 000, 001 or 010.
REQ-013 A spanning access (off+size > 4) SHALL be handled as defined in Configuration.
REQ-014 The second-word address SHALL be first word + 4 modulo 2^ADDR_W, so 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-015 mem_gnt in the same cycle as mem_rvalid SHALL be legal only across different states. No combinational path SHALL exist from mem_* inputs to req_ready.

Reset
REQ-016 While rst=1, the FSM SHALL be IDLE and req_ready=1. resp_valid, resp_err, mem_req and mem_we SHALL be 0, and resp_rdata, mem_addr, mem_wdata and mem_wstrb SHALL be 0.
REQ-017 Reset mid-operation SHALL abandon the access immediately, deasserting mem_req asynchronously. A late mem_rvalid SHALL be ignored and no resp_valid SHALL be produced.

Configuration
REQ-018 With macro LSU_MISALIGN_SPLIT_EN defined, a spanning access SHALL run REQ0, WAIT0, REQ1, WAIT1, RESP. Low lanes go first, load bytes merge across both words, and resp_err=0.
REQ-019 Without LSU_MISALIGN_SPLIT_EN, a spanning access SHALL go directly to RESP with resp_err=1 and no bus transaction. States REQ1 and WAIT1 SHALL be unreachable.

Verification
REQ-020 sw addr 0x100, data 0xDEADBEEF, immediate gnt and rvalid -> single mem_req, addr 0x100, wstrb 1111, wdata 0xDEADBEEF, resp_valid 3 cycles after acceptance, resp_err 0.
REQ-021 lb addr 0x103, mem_rdata 0x80112233 -> resp_rdata 0xFFFFFF80. Same access as lbu -> 0x00000080.
REQ-022 sh addr 0x102, data 0x0000ABCD, mem_gnt delayed 3 cycles -> mem_* held stable, wstrb 1100, wdata 0xABCD0000.
REQ-023 lw addr 0x0FE with SPLIT_EN, words 0x0FC=0x44332211 and 0x100=0x88776655 -> two requests (0x0FC then 0x100), resp_rdata 0x66554433. Without SPLIT_EN -> no mem_req, resp_err=1.
REQ-024 load funct3 111 -> no mem_req, resp_valid with resp_err=1, resp_rdata 0.
REQ-025 rst pulsed in WAIT0, then mem_rvalid arrives -> no resp_valid, req_ready=1, next request served normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: lane steering, sign/zero extension, bus handshake.
// Define LSU_MISALIGN_SPLIT_EN to split word-spanning accesses into two bus transactions.
module load_store_unit #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

   state_t            state;
   logic              lat_we;
   logic [2:0]        lat_funct3;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [31:0]       lo_word;

   // Byte-lane enables over two consecutive words; low nibble is the first word.
   function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
      logic [7:0] m;
      case (sz)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         default: m = 8'h0F;
      endcase
      return m << off;
   endfunction

   function automatic logic [63:0] lane_data(input logic [31:0] d, input logic [1:0] off);
      return {32'h0, d} << {off, 3'b000};
   endfunction

   function automatic logic spans(input logic [1:0] sz, input logic [1:0] off);
      logic [2:0] sum;
      case (sz)
         2'b00:   sum = 3'({1'b0, off}) + 3'd1;
         2'b01:   sum = 3'({1'b0, off}) + 3'd2;
         default: sum = 3'({1'b0, off}) + 3'd4;
      endcase
      return (sz == 2'b10 && off != 2'b00) || sum > 3'd4;
   endfunction

   function automatic logic illegal(input logic we, input logic [2:0] f3);
      if (we) return f3[2] || (f3[1:0] == 2'b11);
      return (f3 == 3'b011) || (f3[2:1] == 2'b11);
   endfunction

   // Pair is {second word, first word}; the access starts at byte off of the pair.
   function automatic logic [31:0] load_ext(input logic [63:0] pair, input logic [1:0] off,
                                            input logic [2:0] f3);
      logic [31:0] d;
      d = 32'(pair >> {off, 3'b000});
      case (f3[1:0])
         2'b00:   return {{24{d[7]  & ~f3[2]}}, d[7:0]};
         2'b01:   return {{16{d[15] & ~f3[2]}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   logic [1:0]        acc_off, lat_off;
   logic              acc_err, lat_spans;
   logic [63:0]       acc_lanes, lat_lanes;
   logic [7:0]        acc_mask, lat_mask;
   logic [ADDR_W-1:0] lat_word;

   assign acc_off   = req_addr[1:0];
   assign acc_err   = illegal(req_we, req_funct3) ||
                      (spans(req_funct3[1:0], acc_off) && !SPLIT_EN);
   assign acc_lanes = lane_data(req_wdata, acc_off);
   assign acc_mask  = lane_mask(req_funct3[1:0], acc_off);
   assign lat_off   = lat_addr[1:0];
   assign lat_spans = spans(lat_funct3[1:0], lat_off);
   assign lat_lanes = lane_data(lat_wdata, lat_off);
   assign lat_mask  = lane_mask(lat_funct3[1:0], lat_off);
   assign lat_word  = {lat_addr[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 32'h0;
         mem_wstrb  <= 4'h0;
         lat_we     <= 1'b0;
         lat_funct3 <= 3'h0;
         lat_addr   <= '0;
         lat_wdata  <= 32'h0;
         lo_word    <= 32'h0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               lat_we     <= req_we;
               lat_funct3 <= req_funct3;
               lat_addr   <= req_addr;
               lat_wdata  <= req_wdata;
               req_ready  <= 1'b0;
               if (acc_err) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 32'h0;
               end else begin
                  state     <= REQ0;
                  mem_req   <= 1'b1;
                  mem_we    <= req_we;
                  mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata <= req_we ? acc_lanes[31:0] : 32'h0;
                  mem_wstrb <= req_we ? acc_mask[3:0] : 4'h0;
               end
            end
            REQ0: if (mem_gnt) begin
               mem_req <= 1'b0;
               state   <= WAIT0;
            end
            WAIT0: if (mem_rvalid) begin
               if (SPLIT_EN && lat_spans) begin
                  lo_word   <= mem_rdata;
                  state     <= REQ1;
                  mem_req   <= 1'b1;
                  mem_addr  <= lat_word + ADDR_W'(4);
                  mem_wdata <= lat_we ? lat_lanes[63:32] : 32'h0;
                  mem_wstrb <= lat_we ? lat_mask[7:4] : 4'h0;
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= lat_we ? 32'h0 : load_ext({32'h0, mem_rdata}, lat_off, lat_funct3);
               end
            end
            REQ1: if (mem_gnt) begin
               mem_req <= 1'b0;
               state   <= WAIT1;
            end
            WAIT1: if (mem_rvalid) begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= lat_we ? 32'h0 : load_ext({mem_rdata, lo_word}, lat_off, lat_funct3);
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
               req_ready  <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               mem_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; follows LSU_MISALIGN_SPLIT_EN if defined.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'h0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int n_vec = 0;
   int n_err = 0;

   load_store_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Present a request for one edge; returns at the first negedge after acceptance.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
      step();
      req_valid = 1'b0; req_wdata = 32'h0;
   endtask

   // Grant now, return read data the next cycle, end in RESP.
   task automatic bus_cycle(input logic [31:0] rd);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("mem_req_after_gnt", 32'(mem_req), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = rd;
      step();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic chk_resp(input string tag, input logic err, input logic [31:0] rd);
      chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_err"}, 32'(resp_err), 32'(err));
      chk({tag, "_rdata"}, resp_rdata, rd);
      step();
      chk({tag, "_done"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      step(); step();
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_wstrb", 32'(mem_wstrb), 32'h0);
      rst = 1'b0;
      step();

      // sw 0x100: best-case latency of three cycles
      issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      chk("sw_req", 32'(mem_req), 32'd1);
      chk("sw_we", 32'(mem_we), 32'd1);
      chk("sw_addr", mem_addr, 32'h100);
      chk("sw_wstrb", 32'(mem_wstrb), 32'hF);
      chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
      chk("sw_busy", 32'(req_ready), 32'd0);
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      chk("sw_wait_noresp", 32'(resp_valid), 32'd0);
      mem_rvalid = 1'b1; step(); mem_rvalid = 1'b0;
      chk("sw_mem_req_resp", 32'(mem_req), 32'd0);
      chk_resp("sw", 1'b0, 32'h0);

      // lb / lbu at offset 3
      issue(1'b0, 3'b000, 32'h103, 32'h0);
      chk("lb_addr", mem_addr, 32'h100);
      chk("lb_we", 32'(mem_we), 32'd0);
      chk("lb_wstrb", 32'(mem_wstrb), 32'h0);
      bus_cycle(32'h80112233);
      chk_resp("lb", 1'b0, 32'hFFFFFF80);
      issue(1'b0, 3'b100, 32'h103, 32'h0);
      bus_cycle(32'h80112233);
      chk_resp("lbu", 1'b0, 32'h00000080);

      // lh / lhu at offset 1
      issue(1'b0, 3'b001, 32'h101, 32'h0);
      bus_cycle(32'h12F00034);
      chk_resp("lh", 1'b0, 32'hFFFFF000);
      issue(1'b0, 3'b101, 32'h101, 32'h0);
      bus_cycle(32'h12F00034);
      chk_resp("lhu", 1'b0, 32'h0000F000);

      // sh 0x102 with grant held off for three cycles
      issue(1'b1, 3'b001, 32'h102, 32'h0000ABCD);
      for (int i = 0; i < 3; i++) begin
         chk("sh_hold_req", 32'(mem_req), 32'd1);
         chk("sh_hold_addr", mem_addr, 32'h100);
         chk("sh_hold_wstrb", 32'(mem_wstrb), 32'hC);
         chk("sh_hold_wdata", mem_wdata, 32'hABCD0000);
         mem_rvalid = 1'b1;
         step();
         mem_rvalid = 1'b0;
      end
      bus_cycle(32'h0);
      chk_resp("sh", 1'b0, 32'h0);

      // sb to the last byte of the address space
      issue(1'b1, 3'b000, 32'hFFFFFFFF, 32'h000000EF);
      chk("sb_top_addr", mem_addr, 32'hFFFFFFFC);
      chk("sb_top_wstrb", 32'(mem_wstrb), 32'h8);
      chk("sb_top_wdata", mem_wdata, 32'hEF000000);
      bus_cycle(32'h0);
      chk_resp("sb_top", 1'b0, 32'h0);

`ifdef LSU_MISALIGN_SPLIT_EN
      issue(1'b0, 3'b010, 32'h0FE, 32'h0);
      chk("lw_split_addr0", mem_addr, 32'h0FC);
      bus_cycle(32'h44332211);
      chk("lw_split_req1", 32'(mem_req), 32'd1);
      chk("lw_split_addr1", mem_addr, 32'h100);
      bus_cycle(32'h88776655);
      chk_resp("lw_split", 1'b0, 32'h66554433);
      issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD);
      chk("sh_wrap_addr0", mem_addr, 32'hFFFFFFFC);
      chk("sh_wrap_wstrb0", 32'(mem_wstrb), 32'h8);
      chk("sh_wrap_wdata0", mem_wdata, 32'hCD000000);
      bus_cycle(32'h0);
      chk("sh_wrap_addr1", mem_addr, 32'h00000000);
      chk("sh_wrap_wstrb1", 32'(mem_wstrb), 32'h1);
      chk("sh_wrap_wdata1", mem_wdata, 32'h000000AB);
      bus_cycle(32'h0);
      chk_resp("sh_wrap", 1'b0, 32'h0);
`else
      issue(1'b0, 3'b010, 32'h0FE, 32'h0);
      chk("lw_span_noreq", 32'(mem_req), 32'd0);
      chk_resp("lw_span", 1'b1, 32'h0);
      issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD);
      chk("sh_span_noreq", 32'(mem_req), 32'd0);
      chk_resp("sh_span", 1'b1, 32'h0);
`endif

      // illegal width codes
      issue(1'b0, 3'b111, 32'h200, 32'h0);
      chk("ld111_noreq", 32'(mem_req), 32'd0);
      chk_resp("ld111", 1'b1, 32'h0);
      issue(1'b1, 3'b100, 32'h200, 32'h0);
      chk("st100_noreq", 32'(mem_req), 32'd0);
      chk_resp("st100", 1'b1, 32'h0);

      // reset in REQ0 drops mem_req without waiting for a clock
      issue(1'b0, 3'b010, 32'h300, 32'h0);
      chk("rst_req0_pre", 32'(mem_req), 32'd1);
      #1 rst = 1'b1;
      #1 chk("rst_req0_async", 32'(mem_req), 32'd0);
      chk("rst_req0_ready", 32'(req_ready), 32'd1);
      step();
      rst = 1'b0;
      step();

      // reset in WAIT0, then a stale mem_rvalid
      issue(1'b0, 3'b010, 32'h200, 32'h0);
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      step();
      mem_rvalid = 1'b0;
      chk("stale_no_resp", 32'(resp_valid), 32'd0);
      chk("stale_ready", 32'(req_ready), 32'd1);
      step();
      chk("stale_no_resp2", 32'(resp_valid), 32'd0);
      issue(1'b0, 3'b010, 32'h204, 32'h0);
      chk("post_rst_addr", mem_addr, 32'h204);
      bus_cycle(32'h12345678);
      chk_resp("post_rst_lw", 1'b0, 32'h12345678);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
